// File: rtl/cpu_pkg.sv
// cpu_pkg: shared fetch-stage constants and the fetch FSM state type
package cpu_pkg;
  localparam logic [31:0] RESET_PC  = 32'hBFC00000;
  localparam logic [31:0] IMEM_BASE = 32'hBFC00000;
  localparam logic [31:0] IMEM_TOP  = 32'hBFC00FFF;
  localparam logic [31:0] NOP_INSTR = 32'h00000013;
  typedef enum logic [1:0] {BOOT, RUN, HALT} fetch_state_t;
endpackage

// File: rtl/fetch_stage_pc_reg.sv
// pc_reg: program counter register with redirect / sequential-advance next-PC mux
module pc_reg #(
  parameter logic [31:0] RESET_PC = cpu_pkg::RESET_PC
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_i,
  input  logic        advance_i,
  input  logic [31:0] target_i,
  output logic [31:0] pc_o
);
  logic [31:0] pc_d, pc_q;
  // redirect wins over advance; otherwise the PC holds
  always_comb pc_d = redirect_i ? target_i : advance_i ? pc_q + 32'd4 : pc_q;
  // PC register, back to the boot vector on reset
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) pc_q <= RESET_PC;
    else pc_q <= pc_d;
  assign pc_o = pc_q;
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: BOOT/RUN/HALT fetch FSM with legality check, IF/ID register and fetch counter
module fetch_stage
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = cpu_pkg::RESET_PC,
  parameter logic [31:0] IMEM_BASE = cpu_pkg::IMEM_BASE,
  parameter logic [31:0] IMEM_TOP  = cpu_pkg::IMEM_TOP
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_target_i,
  input  logic        flush_i,
  output logic [31:0] pc_o,
  input  logic [31:0] instr_i,
  output logic [31:0] if_id_instr_o,
  output logic [31:0] if_id_pc_o,
  output logic [31:0] if_id_pc_plus4_o,
  output logic        if_id_valid_o,
  output logic        fetch_fault_o,
  output logic [31:0] fetch_count_o
);
  fetch_state_t state_q;
  logic [31:0] instr_q, ipc_q, ipc4_q, count_q;
  logic valid_q, fault_q;
  logic run, legal, do_redirect, do_advance, do_fault, do_hold;
  // decode this cycle's action; redirect beats stall beats advance, only in RUN
  always_comb begin
    run         = state_q == RUN;
    legal       = pc_o >= IMEM_BASE && pc_o <= IMEM_TOP - 32'd3 && pc_o[1:0] == 2'b00;
    do_redirect = run && redirect_i;
    do_hold     = run && !redirect_i && stall_i;
    do_advance  = run && !redirect_i && !stall_i && legal;
    do_fault    = run && !redirect_i && !stall_i && !legal;
  end
  pc_reg #(.RESET_PC(RESET_PC)) u_pc_reg (
    .clk       (clk),
    .rst_n     (rst_n),
    .redirect_i(do_redirect),
    .advance_i (do_advance),
    .target_i  (redirect_target_i),
    .pc_o      (pc_o)
  );
  // FSM plus registered IF/ID payload, sticky fault and valid-load counter
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= BOOT;
      instr_q <= NOP_INSTR;
      ipc_q   <= '0;
      ipc4_q  <= '0;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
      count_q <= '0;
    end else begin
      if (state_q == BOOT) state_q <= RUN;
      else if (do_fault) state_q <= HALT;
      if (do_advance) begin
        instr_q <= instr_i;
        ipc_q   <= pc_o;
        ipc4_q  <= pc_o + 32'd4;
      end
      valid_q <= do_advance ? !flush_i : do_hold ? valid_q && !flush_i : 1'b0;
      if (do_fault) fault_q <= 1'b1;
      if (do_advance && !flush_i) count_q <= count_q + 32'd1;
    end
  assign if_id_instr_o    = instr_q;
  assign if_id_pc_o       = ipc_q;
  assign if_id_pc_plus4_o = ipc4_q;
  assign if_id_valid_o    = valid_q;
  assign fetch_fault_o    = fault_q;
  assign fetch_count_o    = count_q;
endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, 32'hBFC00000, first fetch address after reset.
REQ-002 Parameter IMEM_BASE, 32'hBFC00000, lowest legal fetch address.
REQ-003 Parameter IMEM_TOP, 32'hBFC00FFF, highest legal fetch byte address.
REQ-004 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-005 rst_n  input  1  reset; asynchronous and active-low.
REQ-006 stall_i  input  1  hold PC and IF/ID register.
REQ-007 redirect_i  input  1  taken branch/jump; load redirect_target_i.
REQ-008 redirect_target_i  input  32  new PC on redirect.
REQ-009 flush_i  input  1  invalidate IF/ID register.
REQ-010 pc_o  output  32  current PC, driven to instruction memory address.
REQ-011 instr_i  input  32  instruction returned combinationally for pc_o in the same cycle.
REQ-012 if_id_instr_o / if_id_pc_o / if_id_pc_plus4_o  output  32 each  registered IF/ID payload.
REQ-013 if_id_valid_o  output  1  IF/ID payload valid.
REQ-014 fetch_fault_o  output  1  sticky fetch fault (range or alignment).
REQ-015 fetch_count_o  output  32  count of valid IF/ID loads.

Function
REQ-016 FSM states BOOT, RUN, HALT; BOOT SHALL last exactly one cycle after reset release, then go to RUN unconditionally.
REQ-017 In BOOT, PC SHALL hold RESET_PC and no IF/ID load occurs (if_id_valid_o stays 0).
REQ-018 PC legality: legal iff IMEM_BASE <= pc_o <= IMEM_TOP-3 and pc_o[1:0]==0.
REQ-019 RUN, per-edge priority: redirect_i > stall_i > sequential advance.
REQ-020 redirect_i=1 (stall_i ignored): PC <= redirect_target_i; if_id_valid_o <= 0; payload held.
REQ-021 stall_i=1, redirect_i=0: PC, payload and if_id_valid_o held; flush_i=1 still clears if_id_valid_o.
REQ-022 Sequential advance, PC legal: IF/ID <= {instr_i, pc_o, pc_o+4}; if_id_valid_o <= !flush_i; PC <= pc_o+4 (mod 2^32).
REQ-023 Sequential advance, PC illegal: next state HALT; fetch_fault_o <= 1; if_id_valid_o <= 0; PC held.
REQ-024 Illegal redirect target SHALL be accepted into PC and faulted on the following non-stalled, non-redirect cycle, per REQ-023.
REQ-025 Wrap: advance from 32'hBFC00FFC yields 32'hBFC01000, which SHALL fault per REQ-023.
REQ-026 HALT: sticky until reset; PC, payload held; if_id_valid_o=0; all inputs ignored.
REQ-027 fetch_count_o SHALL increment by 1 on each edge where if_id_valid_o is loaded with 1, wrapping 32'hFFFFFFFF -> 0.
REQ-028 Latency: instruction at pc_o in cycle N appears on if_id_instr_o in cycle N+1.

Reset
REQ-029 On rst_n=0, immediately: state BOOT, pc_o=RESET_PC, if_id_instr_o=32'h00000013 (NOP), if_id_pc_o=0, if_id_pc_plus4_o=0, if_id_valid_o=0, fetch_fault_o=0, fetch_count_o=0.
REQ-030 Reset asserted mid-operation (including HALT) SHALL abort all activity with the values of REQ-029.

Structure
REQ-031 Shared package cpu_pkg SHALL hold IMEM_BASE/IMEM_TOP defaults, RESET_PC, NOP_INSTR (32'h00000013), and the fetch_state_t enum.
REQ-032 One sub-module pc_reg SHALL hold the PC register and next-PC mux; FSM, legality check, IF/ID register and counter live in fetch_stage.

Verification
REQ-033 Reset release, no stalls, instr_i=pc-derived -> pc_o 0xBFC00000 for 2 cycles (BOOT), then +4 per cycle; if_id_pc_o lags pc_o by one cycle; fetch_count_o=3 after 3 RUN cycles.
REQ-034 stall_i high 3 cycles at pc 0xBFC00010 -> pc_o and IF/ID frozen, fetch_count_o unchanged; resumes at 0xBFC00014 next.
REQ-035 redirect_i with stall_i, target 0xBFC00100 -> next pc_o=0xBFC00100, if_id_valid_o=0 for one cycle, then if_id_pc_o=0xBFC00100.
REQ-036 redirect to 0xBFC00102 -> one cycle later fetch_fault_o=1, state HALT, pc_o stays 0xBFC00102, if_id_valid_o=0.
REQ-037 Sequential run to 0xBFC00FFC -> that instruction loads validly; pc_o=0xBFC01000 then fault asserts; rst_n pulse mid-HALT -> all outputs per REQ-029.
